vm_mini_msadc_seq: RTL and testbench
====================================

// Module: vm_mini_msadc_seq
// PURPOSE
//  Parametrised multislope ADC sequencer; successor to the fixed-timing vm_mini converter control.
//  Drives integrator switches through reset/runup/settle/rundown; counts runup decisions and fast rundown clocks.
//  Emits one result word per conversion over a valid/ready handshake to the UART framer.
//  All timing is in TICKs: 1-cycle enables from the shared mclk prescaler.
// PARAMETERS
//  RW       15    runup decision counter width; also width of runup_set
//  DW       16    rundown counter width, in mclk cycles
//  PERIOD   100   ticks per runup period
//  PH_MIN   10    ticks of minority phase per period; must be < PERIOD/2
//  RST_T    4000  ticks integrator reset (IDLE->RUNUP path)
//  SET_T    20    ticks settle between runup and rundown
//  RD_T     1200  ticks rundown window
// PORTS
//  mclk          in   1      master clock
//  rst           in   1      synchronous, active-high reset
//  tick          in   1      prescaler enable pulse, 1 mclk wide
//  comp_raw      in   1      integrator comparator, asynchronous; 1 = integrator above threshold
//  start         in   1      level; 1 = convert continuously, 0 = abort to IDLE
//  runup_set     in   RW     runup periods minus 1; sampled on RUNUP entry
//  sw_in,sw_up,sw_dn,sw_rst,sw_vref  out 1  switch controls, active-high; pin polarity is handled at top level
//  busy          out  1      1 in any state except IDLE
//  res_valid     out  1      result word held
//  res_ready     in   1      consumer accepts when res_valid & res_ready
//  res_runup     out  RW     count of periods that ended with comp = 1
//  res_sign      out  1      rundown direction, 1 = up
//  res_set       out  RW     runup_set used for this result
//  res_rundown   out  DW     rundown mclk count
//  res_ovf       out  1      rundown counter saturated
//  res_zero      out  1      result is a zero-input measurement
// BEHAVIOUR
//  - comp_raw passes through a 2-flop synchroniser on mclk (comp_s). All state moves occur on tick, except the rundown counter.
//  - Reset: state = IDLE; sw_rst = 1 and sw_vref = 1; other switches 0; res_valid = 0; result fields 0; counters 0.
//  - IDLE: reset switch pattern. start = 1 at a tick -> RESET.
//  - RESET: sw_rst = 1, sw_vref = 1. After RST_T ticks -> RUNUP. Latch runup_set; clear decision and runup count.
//  - RUNUP: sw_in = 1, sw_vref = 1, sw_rst = 0.
//    - Previous decision 0: sw_dn for the first PERIOD-PH_MIN ticks of the period, then sw_up for PH_MIN ticks.
//    - Previous decision 1: sw_dn for PH_MIN ticks, then sw_up. sw_up and sw_dn are never both 1.
//    - At the last tick of each period: decision <= comp_s, and runup count increments if comp_s = 1.
//    - After runup_set+1 periods -> SETTLE. The final period's comparator value is not counted.
//  - SETTLE: all switches 0 for SET_T ticks. At exit, sign <= comp_s; then -> RUNDOWN.
//  - RUNDOWN: sign = 1 drives sw_up, sign = 0 drives sw_dn. sw_in = sw_vref = sw_rst = 0.
//    - Counter is cleared on entry and increments every mclk while comp_s == sign.
//    - At 2^DW-1 the counter holds and ovf is set.
//    - After RD_T ticks -> REPORT.
//  - REPORT: reset switch pattern.
//    - Load the result registers when res_valid = 0, or res_valid & res_ready in the same cycle.
//    - After the load: start = 1 -> RESET, else -> IDLE.
//    - A full unaccepted buffer stalls REPORT. No result is ever overwritten or dropped.
//  - res_valid rises the cycle after the load. It falls the cycle after the accept if no new load coincides. Fields are stable while valid.
//  - start = 0 in RESET, RUNUP, SETTLE or RUNDOWN: go to IDLE at the next tick, discarding the partial conversion. A held result is kept.
//  - rst mid-conversion: full reset values next cycle, including a pending result.
//  - All tick counters are compared with >= terminal-1. No wrap is reachable.
// CONFIGURATION
//  - MSADC_AUTOZERO_EN defined: conversions alternate input / zero.
//    - Zero conversions hold sw_in = 0 through RUNUP and drive sw_vref identically.
//    - res_zero = 1 on zero results. The first conversion after IDLE is an input conversion.
//  - Undefined: every conversion is an input conversion; res_zero is tied 0.
// TESTING
//  1. rst, start=1, comp_raw=0, runup_set=1, small params -> RST_T ticks reset, 2 periods dn 90/up 10, res_runup=0, res_sign=0, one res_valid.
//  2. comp_raw=1 constant, runup_set=9 -> res_runup=9, res_set=9, res_sign=1, periods after the first use dn 10/up 90.
//  3. comp_raw equal to sign for all of RUNDOWN, DW=8 -> res_rundown=255, res_ovf=1.
//  4. res_ready=0 for 3 conversions -> first result held, sequencer stalled in REPORT, no result lost; res_ready=1 -> three results in order.
//  5. start dropped mid-RUNUP -> IDLE at next tick, no new res_valid, switches at reset pattern; rst mid-RUNDOWN -> all reset values next cycle.
//  6. MSADC_AUTOZERO_EN defined -> res_zero sequence 0,1,0,1; sw_in=0 throughout zero runups.

Source files
------------

// File: rtl/vm_mini_msadc_seq.sv
// Multislope ADC sequencer: reset / runup / settle / rundown / report, tick-timed.
// Optional zero-input alternation under `MSADC_AUTOZERO_EN`.
module vm_mini_msadc_seq #(
    parameter int RW     = 15,
    parameter int DW     = 16,
    parameter int PERIOD = 100,
    parameter int PH_MIN = 10,
    parameter int RST_T  = 4000,
    parameter int SET_T  = 20,
    parameter int RD_T   = 1200
) (
    input  logic          i_mclk,
    input  logic          i_rst,
    input  logic          i_tick,
    input  logic          i_comp_raw,
    input  logic          i_start,
    input  logic [RW-1:0] i_runup_set,
    output logic          o_sw_in,
    output logic          o_sw_up,
    output logic          o_sw_dn,
    output logic          o_sw_rst,
    output logic          o_sw_vref,
    output logic          o_busy,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [RW-1:0] o_res_runup,
    output logic          o_res_sign,
    output logic [RW-1:0] o_res_set,
    output logic [DW-1:0] o_res_rundown,
    output logic          o_res_ovf,
    output logic          o_res_zero
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TMAX = max2(max2(RST_T, PERIOD), max2(SET_T, RD_T));
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] RST_END = TW'(RST_T - 1);
    localparam logic [TW-1:0] PER_END = TW'(PERIOD - 1);
    localparam logic [TW-1:0] SET_END = TW'(SET_T - 1);
    localparam logic [TW-1:0] RD_END  = TW'(RD_T - 1);
    localparam logic [TW-1:0] PH_LO   = TW'(PH_MIN);
    localparam logic [TW-1:0] PH_HI   = TW'(PERIOD - PH_MIN);
    localparam logic [DW-1:0] RD_PRE  = {{(DW-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_RUNUP, S_SETTLE, S_RUNDOWN, S_REPORT
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_cs1;
    logic          r_cs2;
    logic [TW-1:0] r_tcnt;
    logic [TW-1:0] w_term;
    logic          w_last;
    logic [RW-1:0] r_per;
    logic [RW-1:0] r_set;
    logic          r_dec;
    logic [RW-1:0] r_runup;
    logic          r_sign;
    logic [DW-1:0] r_rd;
    logic          r_ovf;
    logic          r_valid;
    logic [RW-1:0] r_res_runup;
    logic          r_res_sign;
    logic [RW-1:0] r_res_set;
    logic [DW-1:0] r_res_rd;
    logic          r_res_ovf;
    logic          r_res_zero;
    logic          w_load;
    logic          w_dn;
    logic          w_zero;

    always_comb begin
        w_term = '0;
        unique case (r_state)
            S_RESET:   w_term = RST_END;
            S_RUNUP:   w_term = PER_END;
            S_SETTLE:  w_term = SET_END;
            S_RUNDOWN: w_term = RD_END;
            default:   w_term = '0;
        endcase
    end

    assign w_last = (r_tcnt >= w_term);
    assign w_dn   = r_dec ? (r_tcnt < PH_LO) : (r_tcnt < PH_HI);
    assign w_load = i_tick && (r_state == S_REPORT)
                  && (!r_valid || i_res_ready);

    always_comb begin
        w_next    = r_state;
        o_sw_in   = 1'b0;
        o_sw_up   = 1'b0;
        o_sw_dn   = 1'b0;
        o_sw_rst  = 1'b0;
        o_sw_vref = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_sw_rst  = 1'b1;
                o_sw_vref = 1'b1;
                if (i_tick && i_start) w_next = S_RESET;
            end
            S_RESET: begin
                o_sw_rst  = 1'b1;
                o_sw_vref = 1'b1;
                if (i_tick) begin
                    if (!i_start)    w_next = S_IDLE;
                    else if (w_last) w_next = S_RUNUP;
                end
            end
            S_RUNUP: begin
                o_sw_in   = !w_zero;
                o_sw_vref = 1'b1;
                o_sw_dn   = w_dn;
                o_sw_up   = !w_dn;
                if (i_tick) begin
                    if (!i_start) w_next = S_IDLE;
                    else if (w_last && (r_per >= r_set))
                        w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (i_tick) begin
                    if (!i_start)    w_next = S_IDLE;
                    else if (w_last) w_next = S_RUNDOWN;
                end
            end
            S_RUNDOWN: begin
                o_sw_up = r_sign;
                o_sw_dn = !r_sign;
                if (i_tick) begin
                    if (!i_start)    w_next = S_IDLE;
                    else if (w_last) w_next = S_REPORT;
                end
            end
            S_REPORT: begin
                o_sw_rst  = 1'b1;
                o_sw_vref = 1'b1;
                if (w_load) w_next = i_start ? S_RESET : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_mclk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_mclk) begin
        if (i_rst) begin
            r_cs1       <= 1'b0;
            r_cs2       <= 1'b0;
            r_tcnt      <= '0;
            r_per       <= '0;
            r_set       <= '0;
            r_dec       <= 1'b0;
            r_runup     <= '0;
            r_sign      <= 1'b0;
            r_rd        <= '0;
            r_ovf       <= 1'b0;
            r_valid     <= 1'b0;
            r_res_runup <= '0;
            r_res_sign  <= 1'b0;
            r_res_set   <= '0;
            r_res_rd    <= '0;
            r_res_ovf   <= 1'b0;
            r_res_zero  <= 1'b0;
        end else begin
            r_cs1 <= i_comp_raw;
            r_cs2 <= r_cs1;
            if (i_tick) begin
                if ((w_next != r_state) || w_last) r_tcnt <= '0;
                else                               r_tcnt <= r_tcnt + TW'(1);
                if (r_state == S_RESET && w_next == S_RUNUP) begin
                    r_set   <= i_runup_set;
                    r_dec   <= 1'b0;
                    r_runup <= '0;
                    r_per   <= '0;
                end
                // decision taken at every period end except the final one
                if (r_state == S_RUNUP && w_next == S_RUNUP && w_last) begin
                    r_dec   <= r_cs2;
                    r_runup <= r_runup + RW'(r_cs2);
                    r_per   <= r_per + RW'(1);
                end
                if (r_state == S_SETTLE && w_next == S_RUNDOWN)
                    r_sign <= r_cs2;
            end
            if (r_state == S_SETTLE && w_next == S_RUNDOWN) begin
                r_rd  <= '0;
                r_ovf <= 1'b0;
            end else if (r_state == S_RUNDOWN && r_cs2 == r_sign && !r_ovf) begin
                r_rd  <= r_rd + DW'(1);
                r_ovf <= (r_rd == RD_PRE);
            end
            if (w_load) begin
                r_valid     <= 1'b1;
                r_res_runup <= r_runup;
                r_res_sign  <= r_sign;
                r_res_set   <= r_set;
                r_res_rd    <= r_rd;
                r_res_ovf   <= r_ovf;
                r_res_zero  <= w_zero;
            end else if (r_valid && i_res_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef MSADC_AUTOZERO_EN
    logic r_zconv;

    // a chain restarting from IDLE always begins with an input conversion
    always_ff @(posedge i_mclk) begin
        if (i_rst)                        r_zconv <= 1'b0;
        else if (r_state == S_IDLE)       r_zconv <= 1'b0;
        else if (w_load && i_start)       r_zconv <= !r_zconv;
    end

    assign w_zero = r_zconv;
`else
    assign w_zero = 1'b0;
`endif

    assign o_busy        = (r_state != S_IDLE);
    assign o_res_valid   = r_valid;
    assign o_res_runup   = r_res_runup;
    assign o_res_sign    = r_res_sign;
    assign o_res_set     = r_res_set;
    assign o_res_rundown = r_res_rd;
    assign o_res_ovf     = r_res_ovf;
    assign o_res_zero    = r_res_zero;

endmodule

// File: tb/tb_vm_mini_msadc_seq.sv
// Bench for vm_mini_msadc_seq: tick-timeline reference model plus result scoreboard.
// Builds with or without MSADC_AUTOZERO_EN.
module tb_vm_mini_msadc_seq;

    localparam int RW     = 4;
    localparam int DW     = 6;
    localparam int PERIOD = 10;
    localparam int PH_MIN = 2;
    localparam int RST_T  = 8;
    localparam int SET_T  = 3;
    localparam int RD_T   = 20;

    typedef struct packed {
        logic [RW-1:0] runup;
        logic          sign;
        logic [RW-1:0] set;
        logic [DW-1:0] rd;
        logic          ovf;
        logic          zero;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          comp;
    logic          start;
    logic [RW-1:0] rset;
    logic          sw_in, sw_up, sw_dn, sw_rst, sw_vref;
    logic          busy, valid, ready;
    logic [RW-1:0] r_runup, r_set;
    logic          r_sign, r_ovf, r_zero;
    logic [DW-1:0] r_rd;
    logic [4:0]    sw;
    res_t          dres;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   tdiv    = 2;
    int   tcnt    = 0;
    int   rdy_mode = 0;
    res_t q[$];

    vm_mini_msadc_seq #(
        .RW(RW), .DW(DW), .PERIOD(PERIOD), .PH_MIN(PH_MIN),
        .RST_T(RST_T), .SET_T(SET_T), .RD_T(RD_T)
    ) dut (
        .i_mclk(clk), .i_rst(rst), .i_tick(tick),
        .i_comp_raw(comp), .i_start(start), .i_runup_set(rset),
        .o_sw_in(sw_in), .o_sw_up(sw_up), .o_sw_dn(sw_dn),
        .o_sw_rst(sw_rst), .o_sw_vref(sw_vref), .o_busy(busy),
        .o_res_valid(valid), .i_res_ready(ready),
        .o_res_runup(r_runup), .o_res_sign(r_sign), .o_res_set(r_set),
        .o_res_rundown(r_rd), .o_res_ovf(r_ovf), .o_res_zero(r_zero)
    );

    assign sw   = {sw_in, sw_up, sw_dn, sw_rst, sw_vref};
    assign dres = {r_runup, r_sign, r_set, r_rd, r_ovf, r_zero};

    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1 >= tdiv) ? 0 : tcnt + 1;
            tick = (tcnt == 0);
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic zexp(input bit z);
`ifdef MSADC_AUTOZERO_EN
        return z;
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                1:       ready = 1'b1;
                2:       ready = 1'b0;
                default: ready = 1'($urandom_range(0, 1));
            endcase
            if (valid && ready) begin
                if (q.size() == 0) check("unexp_res", 1, 0);
                else check("result", dres, q.pop_front());
            end
        end
    end

    task automatic wait_tick(input int n);
        repeat (n) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("to_idle", busy, 0);
    endtask

    task automatic drain();
        int n = 0;
        rdy_mode = 1;
        while (q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        @(negedge clk);
        rdy_mode = 0;
    endtask

    // bits[p]: comparator level during runup period p; bits[set] also
    // covers settle; rdb is the level during rundown.
    task automatic conv(input int set, input logic [7:0] bits,
                        input logic rdb, input bit cont, input bit z);
        res_t e;
        int   up, cnt;
        logic s;
        rset  = RW'(set);
        start = 1'b1;
        comp  = bits[0];
        wait_tick(1);
        check("reset_sw", {busy, sw}, {1'b1, 5'b00011});
        wait_tick(RST_T);
        up = 0;
        for (int p = 0; p <= set; p++) begin
            comp = bits[p];
            for (int k = 0; k < PERIOD; k++) begin
                logic d, dn;
                d  = (p == 0) ? 1'b0 : bits[p-1];
                dn = d ? (k < PH_MIN) : (k < PERIOD - PH_MIN);
                check("runup_sw", sw, {~zexp(z), ~dn, dn, 2'b01});
                wait_tick(1);
            end
            if (p < set) up += int'(bits[p]);
        end
        s = bits[set];
        check("settle_sw", sw, 0);
        wait_tick(SET_T);
        check("rundown_sw", sw, {1'b0, s, ~s, 2'b00});
        comp = rdb;
        wait_tick(RD_T);
        check("report_sw", {busy, sw}, {1'b1, 5'b00011});
        if (!cont) start = 1'b0;
        cnt    = (rdb == s) ? RD_T * tdiv : 2;
        e.runup = RW'(up);
        e.sign  = s;
        e.set   = RW'(set);
        e.rd    = DW'((cnt > 2**DW - 1) ? 2**DW - 1 : cnt);
        e.ovf   = (cnt >= 2**DW - 1);
        e.zero  = zexp(z);
        q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; comp = 1'b0; rset = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctl", {busy, valid, sw}, {2'b00, 5'b00011});
        check("rst_res", dres, 0);
        rst = 1'b0;

        tdiv = 2; rdy_mode = 1;
        conv(1, 8'h00, 1'b0, 0, 0);
        wait_idle();
        conv(7, 8'hFF, 1'b1, 0, 0);
        wait_idle();
        tdiv = 4;
        conv(2, 8'hFF, 1'b1, 0, 0);
        wait_idle();
        drain();

        tdiv = 3; rdy_mode = 1;
        conv(2, 8'h05, 1'b0, 1, 0);
        conv(3, 8'h0A, 1'b1, 1, 1);
        conv(1, 8'h03, 1'b0, 1, 0);
        conv(0, 8'h01, 1'b1, 0, 1);
        wait_idle();
        drain();

        rdy_mode = 2;
        conv(3, 8'h06, 1'b1, 0, 0);
        wait_idle();
        conv(2, 8'h02, 1'b0, 0, 0);
        wait_tick(15);
        check("stall_busy", {busy, valid}, 2'b11);
        check("stall_hold", dres, q[0]);
        rdy_mode = 0;
        wait_idle();
        conv(1, 8'h01, 1'b1, 0, 0);
        wait_idle();
        drain();

        start = 1'b1; comp = 1'b0; rset = RW'(3);
        wait_tick(1 + RST_T + PERIOD + 3);
        start = 1'b0;
        wait_tick(1);
        check("abort_idle", {busy, sw}, {1'b0, 5'b00011});
        repeat (40) @(posedge clk);
        #2;
        check("abort_noval", valid, 0);

        rdy_mode = 2;
        conv(1, 8'h02, 1'b1, 0, 0);
        wait_idle();
        start = 1'b1; rset = RW'(1);
        wait_tick(1 + RST_T + 2 * PERIOD + SET_T + 5);
        check("pre_rst", {busy, valid}, 2'b11);
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        #2;
        check("mid_rst_ctl", {busy, valid, sw}, {2'b00, 5'b00011});
        check("mid_rst_res", dres, 0);
        rst = 1'b0;
        void'(q.pop_front());
        rdy_mode = 0;

        for (int b = 0; b < 6; b++) begin
            int len;
            tdiv = $urandom_range(2, 4);
            len  = $urandom_range(1, 3);
            rdy_mode = (len > 1) ? 1 : 0;
            for (int i = 0; i < len; i++)
                conv($urandom_range(0, 7), 8'($urandom),
                     1'($urandom_range(0, 1)), i < len - 1, i[0]);
            wait_idle();
            rdy_mode = 0;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
